execute: RTL and testbench
==========================

EXECUTE -- requirements
Module: execute

Interface
REQ-001 clock  in  1  sole clock; all state updates on rising edge.
REQ-002 reset_n  in  1  asynchronous, active-low reset.
REQ-003 insn  in  32  instruction from decode; MIPS-I field layout, opcode = bits 31:26, rs 25:21, rt 20:16, rd 15:11, shamt 10:6, funct 5:0, imm 15:0, target 25:0.
REQ-004 pc  in  32  PC+4 of insn.
REQ-005 valid  in  1  insn/pc valid; qualifies capture.
REQ-006 wb_en / wb_addr / wb_data  in  1/5/32  register-file write port.
REQ-007 control  out  9  [8]BR taken branch, [7]JP J/JAL, [6]DMWE store, [5]RWE reg write, [4]RWD wb-from-memory, [3]RDST rd-dest, [2]ALUOP R-type, [1]ALUINB immediate operand B, [0]JR.
REQ-008 exec_out  out  32  ALU result / memory address / link value.
REQ-009 effective_addr  out  32  branch/jump target.
REQ-010 store_data  out  32  rt value for stores; dest_addr  out  5  write-back register; mem_size  out  2  (00 word, 01 byte); load_signed  out  1.

Function
REQ-011 Register file SHALL hold 32x32-bit registers, two combinational reads (rs, rt), one write on rising edge when wb_en=1.
REQ-012 $0 SHALL read 0; writes to $0 SHALL be ignored.
REQ-013 A read of the register being written in the same cycle SHALL return wb_data (write-through bypass).
REQ-014 Decode SHALL be combinational from insn; outputs SHALL register on rising edge when valid=1 (latency 1 cycle); with valid=0 all outputs SHALL hold.
REQ-015 R-type: ADD/ADDU, SUB/SUBU, AND, OR, XOR, NOR, SLT (signed), SLTU, SLL/SRL/SRA (shamt), SLLV/SRLV/SRAV (rs[4:0]), JR (funct 08); RWE=RDST=ALUOP=1 except JR (JR=1, RWE=0).
REQ-016 I-type: ADDI/ADDIU, SLTI, SLTIU (sign-extended imm), ANDI/ORI/XORI (zero-extended), LUI (imm<<16); RWE=ALUINB=1, RDST=0.
REQ-017 Overflow SHALL NOT trap; ADD/ADDI wrap modulo 2^32.
REQ-018 LW/LB/LBU: exec_out = rs + sext(imm), RWE=RWD=ALUINB=1, mem_size 00/01/01, load_signed 0/1/0.
REQ-019 SW/SB: exec_out = rs + sext(imm), DMWE=ALUINB=1, RWE=0, store_data = rt, mem_size 00/01.
REQ-020 BEQ, BNE, BLEZ, BGTZ, BLTZ/BGEZ (opcode 01, rt 0/1): effective_addr = pc + (sext(imm)<<2); BR=1 only when condition true (signed compare vs 0).
REQ-021 J/JAL: effective_addr = {pc[31:28], target, 00}, JP=1; JAL additionally RWE=1, dest_addr=31, exec_out=pc+4.
REQ-022 JR: effective_addr = rs value, exec_out = 0.
REQ-023 dest_addr = rd if RDST, 31 for JAL, else rt.
REQ-024 Non-branch/jump instructions SHALL drive effective_addr = pc.
REQ-025 Unsupported opcode/funct and insn 0 (NOP) SHALL yield control = 0, exec_out = 0, no side effects.

Reset
REQ-026 On reset_n=0, immediately: control, exec_out, effective_addr, store_data, dest_addr, mem_size, load_signed = 0.
REQ-027 Reset register contents: all 0 except $29 = 0x80120000 (stack pointer) and $31 = 0x77777777 (main return address).
REQ-028 Reset asserted mid-operation SHALL discard any pending capture and write; first capture after release uses current inputs.

Verification
REQ-029 Reset, then JR $31 (0x03E00008) valid -> effective_addr 0x77777777, control JR=1.
REQ-030 Write $8=5, $9=7; ADDU $10,$8,$9 (0x01095021) -> next cycle exec_out 12, dest_addr 10, RWE=RDST=ALUOP=1.
REQ-031 BEQ $8,$8,4 (0x11080004), pc 0x80020004 -> effective_addr 0x80020014, BR=1; with $9 in place of rt, BR=0.
REQ-032 J (0x08008040), pc 0x80020008 -> effective_addr 0x80020100, JP=1, RWE=0.
REQ-033 SW $9,8($29) (0xAFA90008) after reset+$9=7 -> exec_out 0x80120008, store_data 7, DMWE=1, RWE=0.
REQ-034 Write $0=0xFFFFFFFF then SLT $1,$0,... with $2=-1: SLT $3,$2,$0 -> exec_out 1; SLTU $3,$2,$0 -> 0; $0 reads 0.

Source files
------------

// File: rtl/execute.sv
// Execute stage: register file, combinational decode/ALU and a
// one-cycle registered result bundle for the MIPS-I integer subset.
module execute (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] insn,
  input  logic [31:0] pc,
  input  logic        valid,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic [8:0]  control,
  output logic [31:0] exec_out,
  output logic [31:0] effective_addr,
  output logic [31:0] store_data,
  output logic [4:0]  dest_addr,
  output logic [1:0]  mem_size,
  output logic        load_signed
);

  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SW     = 6'h2b;

  localparam logic [8:0] C_BR  = 9'h100;
  localparam logic [8:0] C_J   = 9'h080;
  localparam logic [8:0] C_JAL = 9'h0a0;
  localparam logic [8:0] C_ST  = 9'h042;
  localparam logic [8:0] C_LD  = 9'h032;
  localparam logic [8:0] C_R   = 9'h02c;
  localparam logic [8:0] C_I   = 9'h022;
  localparam logic [8:0] C_JR  = 9'h001;

  logic [31:0] rf [32];

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  sh;
  logic [15:0] imm;
  logic [25:0] tgt;

  assign op  = insn[31:26];
  assign rs  = insn[25:21];
  assign rt  = insn[20:16];
  assign rd  = insn[15:11];
  assign sh  = insn[10:6];
  assign fn  = insn[5:0];
  assign imm = insn[15:0];
  assign tgt = insn[25:0];

  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] se;
  logic [31:0] ze;
  logic [31:0] boff;

  // Same-cycle write-back is forwarded so decode never sees stale data
  always_comb begin
    if (rs == 5'd0)
      a = 32'd0;
    else if (wb_en && wb_addr == rs)
      a = wb_data;
    else
      a = rf[rs];
  end

  always_comb begin
    if (rt == 5'd0)
      b = 32'd0;
    else if (wb_en && wb_addr == rt)
      b = wb_data;
    else
      b = rf[rt];
  end

  assign se   = {{16{imm[15]}}, imm};
  assign ze   = {16'd0, imm};
  assign boff = {{14{imm[15]}}, imm, 2'b00};

  logic is_nop;
  logic is_r;
  logic is_imm;
  logic is_ld;
  logic is_st;
  logic is_br;
  logic is_j;
  logic take;

  assign is_nop = (insn == 32'd0);
  assign is_r   = (op == 6'h00) && !is_nop;
  assign is_imm = (op[5:3] == 3'b001);
  assign is_ld  = (op == OP_LW) || (op == OP_LB) || (op == OP_LBU);
  assign is_st  = (op == OP_SW) || (op == OP_SB);
  assign is_br  = (op[5:2] == 4'b0001)
               || (op == OP_REGIMM && rt[4:1] == 4'd0);
  assign is_j   = (op[5:1] == 5'b00001);

  always_comb begin
    take = 1'b0;
    case (op)
      6'h04:     take = (a == b);
      6'h05:     take = (a != b);
      6'h06:     take = ($signed(a) <= 32'sd0);
      6'h07:     take = ($signed(a) > 32'sd0);
      OP_REGIMM: take = rt[0] ? ($signed(a) >= 32'sd0)
                              : ($signed(a) < 32'sd0);
      default:   take = 1'b0;
    endcase
  end

  logic [8:0]  d_ctrl;
  logic [31:0] d_out;
  logic [31:0] d_ea;
  logic [31:0] d_sd;
  logic [4:0]  d_dst;
  logic [1:0]  d_ms;
  logic        d_ls;

  always_comb begin
    d_ctrl = 9'd0;
    d_out  = 32'd0;
    d_ea   = pc;
    d_sd   = 32'd0;
    d_ms   = 2'b00;
    d_ls   = 1'b0;
    unique case (1'b1)
      is_r: begin
        d_ctrl = C_R;
        case (fn)
          6'h20, 6'h21: d_out = a + b;
          6'h22, 6'h23: d_out = a - b;
          6'h24: d_out = a & b;
          6'h25: d_out = a | b;
          6'h26: d_out = a ^ b;
          6'h27: d_out = ~(a | b);
          6'h2a: d_out = {31'd0, $signed(a) < $signed(b)};
          6'h2b: d_out = {31'd0, a < b};
          6'h00: d_out = b << sh;
          6'h02: d_out = b >> sh;
          6'h03: d_out = $signed(b) >>> sh;
          6'h04: d_out = b << a[4:0];
          6'h06: d_out = b >> a[4:0];
          6'h07: d_out = $signed(b) >>> a[4:0];
          6'h08: begin
            d_ctrl = C_JR;
            d_ea   = a;
          end
          default: d_ctrl = 9'd0;
        endcase
      end
      is_imm: begin
        d_ctrl = C_I;
        case (op)
          6'h08, 6'h09: d_out = a + se;
          6'h0a: d_out = {31'd0, $signed(a) < $signed(se)};
          6'h0b: d_out = {31'd0, a < se};
          6'h0c: d_out = a & ze;
          6'h0d: d_out = a | ze;
          6'h0e: d_out = a ^ ze;
          default: d_out = {imm, 16'd0};
        endcase
      end
      is_ld: begin
        d_ctrl = C_LD;
        d_out  = a + se;
        d_ms   = (op == OP_LW) ? 2'b00 : 2'b01;
        d_ls   = (op == OP_LB);
      end
      is_st: begin
        d_ctrl = C_ST;
        d_out  = a + se;
        d_sd   = b;
        d_ms   = (op == OP_SW) ? 2'b00 : 2'b01;
      end
      is_br: begin
        d_ea   = pc + boff;
        d_ctrl = take ? C_BR : 9'd0;
      end
      is_j: begin
        d_ea = {pc[31:28], tgt, 2'b00};
        if (op == OP_JAL) begin
          d_ctrl = C_JAL;
          d_out  = pc + 32'd4;
        end else begin
          d_ctrl = C_J;
        end
      end
      default: d_ctrl = 9'd0;
    endcase
  end

  always_comb begin
    if (d_ctrl[3])
      d_dst = rd;
    else if (is_j && op == OP_JAL)
      d_dst = 5'd31;
    else
      d_dst = rt;
  end

  // Boot image expects a live stack pointer and a return address into main
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 32; k++)
        rf[k] <= 32'd0;
      rf[29] <= 32'h8012_0000;
      rf[31] <= 32'h7777_7777;
    end else if (wb_en && wb_addr != 5'd0) begin
      rf[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      control        <= 9'd0;
      exec_out       <= 32'd0;
      effective_addr <= 32'd0;
      store_data     <= 32'd0;
      dest_addr      <= 5'd0;
      mem_size       <= 2'b00;
      load_signed    <= 1'b0;
    end else if (valid) begin
      control        <= d_ctrl;
      exec_out       <= d_out;
      effective_addr <= d_ea;
      store_data     <= d_sd;
      dest_addr      <= d_dst;
      mem_size       <= d_ms;
      load_signed    <= d_ls;
    end
  end

endmodule

// File: tb/tb_execute.sv
// Bench for the execute stage: directed cases then randomized
// instructions against a behavioural MIPS-I model.
module tb_execute;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] insn = '0;
  logic [31:0] pc = '0;
  logic        valid = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic [8:0]  control;
  logic [31:0] exec_out;
  logic [31:0] effective_addr;
  logic [31:0] store_data;
  logic [4:0]  dest_addr;
  logic [1:0]  mem_size;
  logic        load_signed;

  execute dut (
    .clock(clock), .reset_n(reset_n), .insn(insn), .pc(pc),
    .valid(valid), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .control(control), .exec_out(exec_out),
    .effective_addr(effective_addr), .store_data(store_data),
    .dest_addr(dest_addr), .mem_size(mem_size),
    .load_signed(load_signed)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  logic [31:0] m_rf [32];
  logic        cur_we;
  logic [4:0]  cur_wa;
  logic [31:0] cur_wd;

  logic [8:0]  e_ctrl, cmask;
  logic [31:0] e_out, e_ea, e_sd;
  logic [4:0]  e_dst;
  logic [1:0]  e_ms;
  logic        e_ls, ce, csd, cdst, cmem;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 32; k++) m_rf[k] = 32'd0;
    m_rf[29] = 32'h8012_0000;
    m_rf[31] = 32'h7777_7777;
    e_ctrl = '0; cmask = 9'h1ff; e_out = '0; e_ea = '0; e_sd = '0;
    e_dst = '0; e_ms = '0; e_ls = 1'b0;
    ce = 1'b1; csd = 1'b1; cdst = 1'b1; cmem = 1'b1;
  endtask

  function automatic logic [31:0] rv(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (cur_we && cur_wa == r) return cur_wd;
    return m_rf[r];
  endfunction

  task automatic predict(input logic [31:0] i, input logic [31:0] p);
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] a, b, se, ze;
    int          sa, sb, sse;
    bit          ok;
    bit          tk;
    op = i[31:26]; fn = i[5:0];
    a = rv(i[25:21]); b = rv(i[20:16]);
    se = {{16{i[15]}}, i[15:0]}; ze = {16'h0, i[15:0]};
    sa = a; sb = b; sse = se;
    e_ctrl = '0; cmask = 9'h1ff; e_out = '0; ce = 1'b1; e_ea = p;
    e_sd = '0; csd = 1'b0; cmem = 1'b0; e_ms = '0; e_ls = 1'b0;
    if (i == 32'd0) begin
    end else if (op == 6'h00) begin
      ok = 1'b1;
      case (fn)
        6'h20, 6'h21: e_out = a + b;
        6'h22, 6'h23: e_out = a - b;
        6'h24: e_out = a & b;
        6'h25: e_out = a | b;
        6'h26: e_out = a ^ b;
        6'h27: e_out = ~(a | b);
        6'h2a: e_out = (sa < sb) ? 1 : 0;
        6'h2b: e_out = (a < b) ? 1 : 0;
        6'h00: e_out = b << i[10:6];
        6'h02: e_out = b >> i[10:6];
        6'h03: e_out = sb >>> i[10:6];
        6'h04: e_out = b << a[4:0];
        6'h06: e_out = b >> a[4:0];
        6'h07: e_out = sb >>> a[4:0];
        6'h08: begin
          ok = 1'b0; e_ctrl = 9'h001; cmask = 9'h021; e_ea = a;
        end
        default: ok = 1'b0;
      endcase
      if (ok) e_ctrl = 9'h02c;
    end else if (op >= 6'h08 && op <= 6'h0f) begin
      e_ctrl = 9'h022;
      case (op)
        6'h08, 6'h09: e_out = a + se;
        6'h0a: e_out = (sa < sse) ? 1 : 0;
        6'h0b: e_out = (a < se) ? 1 : 0;
        6'h0c: e_out = a & ze;
        6'h0d: e_out = a | ze;
        6'h0e: e_out = a ^ ze;
        default: e_out = ze * 65536;
      endcase
    end else if (op == 6'h23 || op == 6'h20 || op == 6'h24) begin
      e_ctrl = 9'h032; e_out = a + se; cmem = 1'b1;
      e_ms = (op == 6'h23) ? 2'b00 : 2'b01;
      e_ls = (op == 6'h20);
    end else if (op == 6'h2b || op == 6'h28) begin
      e_ctrl = 9'h042; e_out = a + se; cmem = 1'b1;
      csd = 1'b1; e_sd = b;
      e_ms = (op == 6'h2b) ? 2'b00 : 2'b01;
    end else if ((op >= 6'h04 && op <= 6'h07) ||
                 (op == 6'h01 && i[20:17] == 4'd0)) begin
      ce = 1'b0;
      e_ea = p + se * 4;
      case (op)
        6'h04: tk = (a == b);
        6'h05: tk = (a != b);
        6'h06: tk = (sa <= 0);
        6'h07: tk = (sa > 0);
        default: tk = i[16] ? (sa >= 0) : (sa < 0);
      endcase
      if (tk) e_ctrl = 9'h100;
    end else if (op == 6'h02 || op == 6'h03) begin
      e_ea = {p[31:28], i[25:0], 2'b00};
      e_ctrl = (op == 6'h03) ? 9'h0a0 : 9'h080;
      if (op == 6'h03) e_out = p + 4;
    end
    if (e_ctrl[3]) e_dst = i[15:11];
    else if (op == 6'h03) e_dst = 5'd31;
    else e_dst = i[20:16];
    cdst = e_ctrl[5];
  endtask

  task automatic check_all();
    chk("control", 32'(control & cmask), 32'(e_ctrl & cmask));
    chk("effective_addr", effective_addr, e_ea);
    if (ce) chk("exec_out", exec_out, e_out);
    if (cdst) chk("dest_addr", 32'(dest_addr), 32'(e_dst));
    if (csd) chk("store_data", store_data, e_sd);
    if (cmem) begin
      chk("mem_size", 32'(mem_size), 32'(e_ms));
      chk("load_signed", 32'(load_signed), 32'(e_ls));
    end
  endtask

  task automatic step(input logic [31:0] i, input logic [31:0] p,
                      input logic v, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd);
    @(negedge clock);
    insn = i; pc = p; valid = v;
    wb_en = we; wb_addr = wa; wb_data = wd;
    cur_we = we; cur_wa = wa; cur_wd = wd;
    if (v) predict(i, p);
    if (we && wa != 5'd0) m_rf[wa] = wd;
    @(posedge clock);
    #1;
    check_all();
  endtask

  logic [5:0] rfn [18] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                          6'h26, 6'h27, 6'h2a, 6'h2b, 6'h00, 6'h02,
                          6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h3f};
  logic [5:0] mops [5] = '{6'h23, 6'h20, 6'h24, 6'h2b, 6'h28};

  initial begin
    logic [31:0] ri, rp, rd_;
    logic [4:0]  rs_, rt_, wa;
    logic [5:0]  op;
    m_reset();
    cur_we = 1'b0; cur_wa = '0; cur_wd = '0;
    #1;
    check_all();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    step(32'h03E00008, 32'h80020000, 1, 0, 0, 0);
    chk("jr_target", effective_addr, 32'h7777_7777);
    chk("jr_bit", 32'(control[0]), 32'd1);

    step(32'h0, 32'h0, 0, 1, 5'd8, 32'd5);
    step(32'h0, 32'h0, 0, 1, 5'd9, 32'd7);
    step(32'h01095021, 32'h80020000, 1, 0, 0, 0);
    chk("addu_sum", exec_out, 32'd12);
    chk("addu_dest", 32'(dest_addr), 32'd10);
    chk("addu_ctl", 32'(control[5:2]), 32'hb);

    step(32'h11080004, 32'h80020004, 1, 0, 0, 0);
    chk("beq_target", effective_addr, 32'h80020014);
    chk("beq_taken", 32'(control[8]), 32'd1);
    step(32'h11090004, 32'h80020004, 1, 0, 0, 0);
    chk("beq_not_taken", 32'(control[8]), 32'd0);

    step(32'h08008040, 32'h80020008, 1, 0, 0, 0);
    chk("j_target", effective_addr, 32'h80020100);
    chk("j_ctl", 32'(control[7:5]), 32'h4);

    step(32'hAFA90008, 32'h8002000c, 1, 0, 0, 0);
    chk("sw_addr", exec_out, 32'h80120008);
    chk("sw_data", store_data, 32'd7);
    chk("sw_ctl", 32'(control[6:5]), 32'h2);

    step(32'h0, 32'h0, 0, 1, 5'd0, 32'hffffffff);
    step(32'h0, 32'h0, 0, 1, 5'd2, 32'hffffffff);
    step(32'h0040182A, 32'h80020010, 1, 0, 0, 0);
    chk("slt_neg", exec_out, 32'd1);
    step(32'h0040182B, 32'h80020014, 1, 0, 0, 0);
    chk("sltu_neg", exec_out, 32'd0);
    step(32'h00002025, 32'h80020018, 1, 0, 0, 0);
    chk("zero_reg", exec_out, 32'd0);

    step(32'h0, 32'h8002001c, 1, 0, 0, 0);
    chk("nop_ctl", 32'(control), 32'd0);
    chk("nop_pc", effective_addr, 32'h8002001c);

    step(32'h01095021, 32'h80020020, 1, 1, 5'd8, 32'd100);
    chk("bypass_sum", exec_out, 32'd107);
    step(32'hffffffff, 32'h11111111, 0, 0, 0, 0);
    chk("hold", exec_out, 32'd107);

    // asynchronous reset in the middle of a capture and a $29 write
    @(negedge clock);
    insn = 32'h27A50004; pc = 32'h80020024; valid = 1'b1;
    wb_en = 1'b1; wb_addr = 5'd29; wb_data = 32'h1234;
    #2 reset_n = 1'b0;
    m_reset();
    #1;
    check_all();
    @(posedge clock);
    #1;
    check_all();
    @(negedge clock);
    wb_en = 1'b0; reset_n = 1'b1;
    cur_we = 1'b0;
    predict(insn, pc);
    @(posedge clock);
    #1;
    check_all();
    chk("post_reset_sp", exec_out, 32'h80120004);

    for (int n = 0; n < 400; n++) begin
      rs_ = 5'($urandom_range(0, 31));
      rt_ = 5'($urandom_range(0, 31));
      rd_ = $urandom;
      case ($urandom_range(0, 8))
        0, 1, 2: ri = {6'h00, rs_, rt_, rd_[15:6],
                       rfn[$urandom_range(0, 17)]};
        3: begin
          op = 6'h08 + 6'($urandom_range(0, 7));
          ri = {op, rs_, rt_, rd_[15:0]};
        end
        4: ri = {mops[$urandom_range(0, 4)], rs_, rt_, rd_[15:0]};
        5: begin
          op = 6'h04 + 6'($urandom_range(0, 3));
          ri = {op, rs_, rt_, rd_[15:0]};
        end
        6: ri = {6'h01, rs_, 5'($urandom_range(0, 2)), rd_[15:0]};
        7: ri = {6'h02 + 6'($urandom_range(0, 1)), rd_[25:0]};
        default: ri = ($urandom_range(0, 1) == 0) ? 32'h0
                      : {6'h3f, rd_[25:0]};
      endcase
      rp = {$urandom, 2'b00};
      wa = ($urandom_range(0, 3) == 0) ? rs_ : 5'($urandom_range(0, 31));
      step(ri, rp, ($urandom_range(0, 7) != 0),
           1'($urandom_range(0, 1)), wa, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
